scc_ocm_bridge: RTL
===================

# scc_ocm_bridge

Parametrised bus bridge between the OCM slot bus (req/ack, 16-bit address) and an external `scc_core` instance. It replaces the fixed-latency, combinational-strobe adapter with a registered handshake FSM, configurable ack latency and RAM address width, and a stereo/mono audio scaler with saturation. The bridge sits at the cartridge top; the core is instantiated beside it, and the bridge drives the core's request/active pins.

## Interface
Parameters
- `RAM_ADR_W`, 21: external RAM address width, at least 14; `core_mem_a` is `RAM_ADR_W-13` bits.
- `ACK_DELAY`, 2: extra wait cycles before ack, 0..15.
- `CORE_W`, 11: signed core sample width.
- `OUT_W`, 15: signed output sample width, at least `CORE_W+1`.
- `GAIN_SHIFT`, 3: left shift applied to samples.
- `STEREO`, 1: 1 passes L/R through separately; 0 drives both outputs with the mono mix.

Ports
- `clk21m` in 1: 21.47727 MHz, the only clock.
- `nreset` in 1: reset, synchronous, active-low.
- `req` in 1: bus request, held high by the master until ack.
- `wrt` in 1: 1 means write.
- `adr` in 16: bus address.
- `dbo` in 8: write data.
- `ack` out 1: one-cycle acknowledge.
- `dbi` out 8: read data, registered.
- `ramreq` out 1: one-cycle RAM strobe.
- `ramwrt` out 1: RAM write qualifier.
- `ramadr` out `RAM_ADR_W`: RAM address.
- `ramdbi` in 8: RAM read data.
- `ramdbo` out 8: RAM write data.
- `core_wrreq`, `core_rdreq` out 1: one-cycle core strobes.
- `core_wr_active`, `core_rd_active` out 1: transaction-in-progress flags.
- `core_a` out 15 and `core_d` out 8: latched address and data.
- `core_q` in 8: core read data.
- `core_mem_ncs` in 1: 0 selects the RAM path.
- `core_mem_a` in `RAM_ADR_W-13`: RAM page from the core.
- `core_left`, `core_right` in `CORE_W`: core samples.
- `wavl`, `wavr` out `OUT_W`: scaled samples, registered.

## Operation
- FSM states: IDLE, ISSUE, DISPATCH, WAIT, ACK, HOLD.
- IDLE: on `req=1`, latch `adr[14:0]`, `wrt` and `dbo` into `core_a`, `ramwrt` and `core_d`/`ramdbo`, then go to ISSUE.
- ISSUE: pulse `core_wrreq` if the latched `wrt` is 1, otherwise `core_rdreq`. The matching `*_active` flag rises here and stays high through ACK.
- DISPATCH: sample `core_mem_ncs` into the path flag. If it is 0, assert `ramreq=1` and set `ramadr={core_mem_a, core_a[12:0]}`, holding `ramadr` until IDLE. Go to WAIT if `ACK_DELAY>0`, else to ACK.
- WAIT: count down `ACK_DELAY` cycles.
- Read data: in the last cycle before ACK, register `dbi` from `ramdbi` on the RAM path or `core_q` otherwise. Writes leave `dbi` unchanged.
- ACK: `ack=1` for exactly one cycle; clear the `*_active` flags.
- HOLD: stay while `req=1`, then go to IDLE when `req=0`. This prevents a request still held after ack from being serviced twice.
- Audio, updated every cycle independent of the FSM:
  - Stereo: `s = sext(core_x)`.
  - Mono: `s = (sext(core_left) + sext(core_right)) >>> 1`, arithmetic shift, computed at `CORE_W+1` bits.
  - Output: `s << GAIN_SHIFT`, saturated to the `OUT_W` signed range.
- Reset (`nreset=0` at a rising edge), including mid-transaction:
  - Next state is IDLE; no ack is emitted.
  - `ack`, `ramreq`, all core strobes and active flags go to 0.
  - `dbi=8'hFF`, `wavl=wavr=0`, `ramadr=0`, `core_a=0`.

## Timing
- Let T0 be the edge where IDLE samples `req=1`.
- Events: `core_*req` high in T0+1, `ramreq` high in T0+2, `dbi` valid from T0+3+`ACK_DELAY`, `ack` high in T0+3+`ACK_DELAY`.
- Minimum request-to-request spacing: `ACK_DELAY`+5 cycles.
- Audio latency: 1 cycle from `core_left`/`core_right` to `wavl`/`wavr`.
- No combinational path from bus inputs to any output.

## Structure
- Package `scc_ocm_pkg`: FSM state enum, `CORE_ADR_W=15`, `RAM_PAGE_LSB=13`, `DBI_RESET=8'hFF`.
- Sub-module `scc_audio_scaler`: sign-extend, shift and saturate, one register stage. Instantiate it twice; in mono mode both instances receive the mix.

## Test plan
- Core read, `ACK_DELAY=2`: `adr=16'h9880`, `core_mem_ncs=1`, `core_q=8'h5A` -> `core_rdreq` at T0+1, no `ramreq`, `ack` and `dbi=8'h5A` at T0+5.
- RAM write: `adr=16'h5123`, `core_mem_ncs=0`, `core_mem_a=8'h0C`, `dbo=8'h77` -> `ramreq`/`ramwrt` at T0+2, `ramadr=21'h019123`, `ramdbo=8'h77`, `ack` at T0+5.
- Held req: `req` held 4 cycles past ack -> exactly one `ack` and one `core_wrreq`; the next request is accepted only after `req=0`.
- Audio saturation with `CORE_W=11`, `OUT_W=12`, `GAIN_SHIFT=3`: `core_left=11'h3FF` -> `wavl=12'h7FF`; `core_left=11'h400` -> `wavl=12'h800`. With defaults, `core_left=-1` -> `wavl=-8`.
- Mono mode (`STEREO=0`): `core_left=100`, `core_right=-40` -> `wavl=wavr=240`.
- Reset mid-op: `nreset=0` in a WAIT cycle -> no `ack`, `core_rd_active=0`, `dbi=8'hFF` next cycle; a new request after release completes normally.

Source files
------------

// File: rtl/scc_ocm_pkg.sv
// scc_ocm_pkg: shared types and constants for the OCM-to-SCC bridge.
package scc_ocm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DISPATCH, S_WAIT, S_ACK, S_HOLD} state_t;
  localparam int CORE_ADR_W = 15;
  localparam int RAM_PAGE_LSB = 13;
  localparam logic [7:0] DBI_RESET = 8'hFF;
endpackage

// File: rtl/scc_audio_scaler.sv
// scc_audio_scaler: left-shift a signed sample and saturate it to the output range, one register stage.
module scc_audio_scaler #(
  parameter int IN_W = 12,
  parameter int OUT_W = 15,
  parameter int GAIN_SHIFT = 3
) (
  input  logic                    clk21m,
  input  logic                    nreset,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  // Wide enough that the shift itself can never overflow before clamping.
  localparam int WW = (IN_W + GAIN_SHIFT > OUT_W) ? IN_W + GAIN_SHIFT : OUT_W;
  localparam logic signed [WW-1:0] MAXV = WW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [WW-1:0] MINV = ~MAXV;
  logic signed [WW-1:0] w;
  always_comb w = WW'(din) <<< GAIN_SHIFT;
  always_ff @(posedge clk21m)
    if (!nreset) dout <= '0;
    else dout <= (w > MAXV) ? OUT_W'(MAXV) : (w < MINV) ? OUT_W'(MINV) : OUT_W'(w);
endmodule

// File: rtl/scc_ocm_bridge.sv
// scc_ocm_bridge: registered req/ack handshake between the OCM slot bus and an scc_core, plus audio scaling.
module scc_ocm_bridge
  import scc_ocm_pkg::*;
#(
  parameter int RAM_ADR_W = 21,
  parameter int ACK_DELAY = 2,
  parameter int CORE_W = 11,
  parameter int OUT_W = 15,
  parameter int GAIN_SHIFT = 3,
  parameter bit STEREO = 1
) (
  input  logic                          clk21m,
  input  logic                          nreset,
  input  logic                          req,
  input  logic                          wrt,
  input  logic [15:0]                   adr,
  input  logic [7:0]                    dbo,
  output logic                          ack,
  output logic [7:0]                    dbi,
  output logic                          ramreq,
  output logic                          ramwrt,
  output logic [RAM_ADR_W-1:0]          ramadr,
  input  logic [7:0]                    ramdbi,
  output logic [7:0]                    ramdbo,
  output logic                          core_wrreq,
  output logic                          core_rdreq,
  output logic                          core_wr_active,
  output logic                          core_rd_active,
  output logic [CORE_ADR_W-1:0]         core_a,
  output logic [7:0]                    core_d,
  input  logic [7:0]                    core_q,
  input  logic                          core_mem_ncs,
  input  logic [RAM_ADR_W-RAM_PAGE_LSB-1:0] core_mem_a,
  input  logic signed [CORE_W-1:0]      core_left,
  input  logic signed [CORE_W-1:0]      core_right,
  output logic signed [OUT_W-1:0]       wavl,
  output logic signed [OUT_W-1:0]       wavr
);
  localparam int IN_W = CORE_W + 1;
  state_t state;
  logic [3:0] cnt;
  logic ram_path;
  logic unused_adr;
  logic signed [IN_W-1:0] sl, sr, mix, in_l, in_r;
  assign unused_adr = adr[15];
  always_ff @(posedge clk21m)
    if (!nreset) begin
      state <= S_IDLE;
      ack <= 1'b0;
      dbi <= DBI_RESET;
      ramreq <= 1'b0;
      ramwrt <= 1'b0;
      ramadr <= '0;
      ramdbo <= '0;
      core_wrreq <= 1'b0;
      core_rdreq <= 1'b0;
      core_wr_active <= 1'b0;
      core_rd_active <= 1'b0;
      core_a <= '0;
      core_d <= '0;
      cnt <= '0;
      ram_path <= 1'b0;
    end else begin
      ack <= 1'b0;
      ramreq <= 1'b0;
      core_wrreq <= 1'b0;
      core_rdreq <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          core_a <= adr[CORE_ADR_W-1:0];
          ramwrt <= wrt;
          core_d <= dbo;
          ramdbo <= dbo;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          core_wrreq <= ramwrt;
          core_rdreq <= !ramwrt;
          core_wr_active <= ramwrt;
          core_rd_active <= !ramwrt;
          state <= S_DISPATCH;
        end
        S_DISPATCH: begin
          ram_path <= !core_mem_ncs;
          if (!core_mem_ncs) begin
            ramreq <= 1'b1;
            ramadr <= {core_mem_a, core_a[RAM_PAGE_LSB-1:0]};
          end
          cnt <= 4'(ACK_DELAY - 1);
          state <= (ACK_DELAY > 0) ? S_WAIT : S_ACK;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= S_ACK;
        end
        S_ACK: begin
          ack <= 1'b1;
          core_wr_active <= 1'b0;
          core_rd_active <= 1'b0;
          if (!ramwrt) dbi <= ram_path ? ramdbi : core_q;
          state <= S_HOLD;
        end
        S_HOLD: if (!req) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  // The mix is formed one bit wider so the sum cannot overflow before halving.
  always_comb begin
    sl = IN_W'(core_left);
    sr = IN_W'(core_right);
    mix = (sl + sr) >>> 1;
    in_l = STEREO ? sl : mix;
    in_r = STEREO ? sr : mix;
  end
  scc_audio_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)) u_scale_l (
    .clk21m(clk21m), .nreset(nreset), .din(in_l), .dout(wavl)
  );
  scc_audio_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)) u_scale_r (
    .clk21m(clk21m), .nreset(nreset), .din(in_r), .dout(wavr)
  );
endmodule
